// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types for the multi-cycle multiply/divide unit.
//   state_t   - IDLE / RUN / FIN sequencer states
//   op_t      - OP_MULT / OP_DIV operation latched at start
//   cnt_width - iteration counter width, $clog2(iter+1)
package multdiv_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   typedef enum logic {OP_MULT, OP_DIV} op_t;

   function automatic int cnt_width(input int iter);
      return $clog2(iter + 1);
   endfunction

endpackage

// File: rtl/mult_div_step.sv
// mult_div_step: one combinational iteration, radix-2 Booth or restoring divide.
//   op      in   OP_MULT / OP_DIV
//   acc     in   2W+1-bit accumulator
//                mult: {A[W-1:0], Q[W-1:0], q_m1}
//                div : {R[W:0], Q[W-1:0]}
//   m       in   multiplicand (mult) or divisor magnitude (div)
//   acc_nxt out  accumulator after one step
module mult_div_step
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  op_t              op,
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH-1:0] m,
   output logic [2*WIDTH:0] acc_nxt
);

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   addend;
   logic [WIDTH:0]   bsum;
   logic [2*WIDTH:0] sh;
   logic [WIDTH+1:0] diff;

   always_comb begin
      // Booth: the add is done one bit wider than A so that subtracting the
      // most negative multiplicand cannot overflow before the shift.
      m_ext  = {m[WIDTH-1], m};
      addend = (acc[1:0] == 2'b01) ? m_ext :
               (acc[1:0] == 2'b10) ? -m_ext : '0;
      bsum   = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + addend;
      // Restoring divide: shift {R,Q} left, keep the trial difference if it
      // did not go negative and shift in a quotient 1.
      sh     = {acc[2*WIDTH-1:0], 1'b0};
      diff   = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, m};
      acc_nxt = (op == OP_MULT) ? {bsum, acc[WIDTH:1]} :
                diff[WIDTH+1]   ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply/divide writing HI/LO.
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   mult_start  in   pulse: signed op_a * op_b
//   div_start   in   pulse: signed op_a / op_b (mult wins if both)
//   op_a, op_b  in   operands, sampled on the accepting edge only
//   busy        out  operation in flight
//   mult_done   out  one-cycle pulse, {hi,lo} = product
//   div_done    out  one-cycle pulse, hi = remainder, lo = quotient
//   div_zero    out  only with MULTDIV_DIVZERO_EN: zero-divisor pulse
//   hi, lo      out  result registers, change only when an op finishes
// Optional: define MULTDIV_DIVZERO_EN to short-cut division by zero.
module mult_div_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             mult_done,
   output logic             div_done,
`ifdef MULTDIV_DIVZERO_EN
   output logic             div_zero,
`endif
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_width(ITER);

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH:0]   acc_q, acc_d, step_acc;
   logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
   logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic               mdone_q, mdone_d, ddone_q, ddone_d;
   logic               start, dz_hit;

   assign start = mult_start | div_start;
   assign a_abs = op_a[WIDTH-1] ? -op_a : op_a;
   assign b_abs = op_b[WIDTH-1] ? -op_b : op_b;
   assign quo   = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULTDIV_DIVZERO_EN
   assign dz_hit = div_start & ~mult_start & (op_b == '0);
`else
   assign dz_hit = 1'b0;
`endif

   mult_div_step #(.WIDTH(WIDTH)) u_step (
      .op      (op_q),
      .acc     (acc_q),
      .m       (m_q),
      .acc_nxt (step_acc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = (state_q == IDLE) ? (start ? (dz_hit ? FIN : RUN) : IDLE) :
                (state_q == RUN)  ? ((cnt_q == CW'(ITER - 1)) ? FIN : RUN) : IDLE;
   end

   always_comb begin
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mdone_d = 1'b0;
      ddone_d = 1'b0;
      if (state_q == IDLE && start) begin
         op_d   = mult_start ? OP_MULT : OP_DIV;
         acc_d  = mult_start ? {{WIDTH{1'b0}}, op_b, 1'b0} : {{(WIDTH+1){1'b0}}, a_abs};
         m_d    = mult_start ? op_a : b_abs;
         qneg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
         rneg_d = op_a[WIDTH-1];
         cnt_d  = '0;
         dz_d   = dz_hit;
      end
      if (state_q == RUN) begin
         acc_d = step_acc;
         cnt_d = cnt_q + 1'b1;
      end
      if (state_q == FIN) begin
         mdone_d = (op_q == OP_MULT);
         ddone_d = (op_q == OP_DIV);
         if (op_q == OP_MULT) {hi_d, lo_d} = acc_q[2*WIDTH:1];
         else if (!dz_q) begin
            hi_d = rem;
            lo_d = quo;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         mdone_q <= 1'b0;
         ddone_q <= 1'b0;
      end else begin
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mdone_q <= mdone_d;
         ddone_q <= ddone_d;
      end
   end

`ifdef MULTDIV_DIVZERO_EN
   logic dzo_q, dzo_d;

   always_comb begin
      dzo_d = (state_q == FIN) & dz_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) dzo_q <= 1'b0;
      else        dzo_q <= dzo_d;
   end

   assign div_zero = dzo_q;
`endif

   assign busy      = (state_q != IDLE);
   assign mult_done = mdone_q;
   assign div_done  = ddone_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (either macro setting).
module tb_mult_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sb[$];

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         mult_start = 1'b0;
   logic         div_start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         busy, mult_done, div_done;
   logic [W-1:0] hi, lo;
`ifdef MULTDIV_DIVZERO_EN
   logic         div_zero;
`endif

   int passed = 0;
   int total  = 0;

   int           r_n, poke_at;
   logic         r_md, r_dd, r_dz, r_busy, r_busy1, r_after;
   logic [W-1:0] r_hi, r_lo;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .mult_done  (mult_done),
      .div_done   (div_done),
`ifdef MULTDIV_DIVZERO_EN
      .div_zero   (div_zero),
`endif
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clock = ~clock;

   // Drives one start pulse and waits (bounded) for a done; records what it saw.
   // r_n is the number of edges after the accepting edge, 0 if none came.
   task automatic run_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      mult_start = m;
      div_start  = d;
      op_a       = a;
      op_b       = b;
      @(posedge clock);
      r_n = 0; r_md = 0; r_dd = 0; r_dz = 0; r_busy = 1'bx; r_after = 1'bx;
      @(negedge clock);
      mult_start = 0;
      div_start  = 0;
      op_a       = $urandom;
      op_b       = $urandom;
      r_busy1    = busy;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clock);
         @(negedge clock);
         div_start = (poke_at > 0 && k == poke_at - 1);
         if (mult_done || div_done) begin
            r_n    = k;
            r_md   = mult_done;
            r_dd   = div_done;
            r_busy = busy;
            r_hi   = hi;
            r_lo   = lo;
`ifdef MULTDIV_DIVZERO_EN
            r_dz   = div_zero;
`endif
            break;
         end
      end
      div_start = 0;
      @(negedge clock);
      r_after = mult_done | div_done;
`ifdef MULTDIV_DIVZERO_EN
      r_after = r_after | div_zero;
`endif
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      total++; if ({busy, mult_done, div_done} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {busy, mult_done, div_done}); else passed++;
      total++; if ({hi, lo} !== '0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passed++;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      total++; if ({busy, mult_done, div_done, hi, lo} !== '0) $display("FAIL after_release: got %h want 0", {busy, mult_done, div_done, hi, lo}); else passed++;
   endtask

   task automatic test_mult;
      logic [W-1:0] ta[8];
      logic [W-1:0] tb[8];
      longint       p;
      exp_t         e;
      ta[0] = 32'd7;          tb[0] = 32'hFFFFFFFD;
      ta[1] = 32'h80000000;   tb[1] = 32'h80000000;
      ta[2] = 32'hFFFFFFFF;   tb[2] = 32'hFFFFFFFF;
      ta[3] = 32'h7FFFFFFF;   tb[3] = 32'h80000000;
      ta[4] = 32'd0;          tb[4] = 32'h12345678;
      for (int i = 5; i < 8; i++) begin ta[i] = $urandom; tb[i] = $urandom; end
      for (int i = 0; i < 8; i++) begin
         p = longint'($signed(ta[i])) * longint'($signed(tb[i]));
         e.hi = p[63:32];
         e.lo = p[31:0];
         sb.push_back(e);
         run_op(1'b1, 1'b0, ta[i], tb[i]);
         e = sb.pop_front();
         total++; if (r_n !== LAT) $display("FAIL mult%0d_latency: got %0d want %0d", i, r_n, LAT); else passed++;
         total++; if ({r_md, r_dd} !== 2'b10) $display("FAIL mult%0d_done: got %b want 10", i, {r_md, r_dd}); else passed++;
         total++; if ({r_busy1, r_busy} !== 2'b10) $display("FAIL mult%0d_busy: got %b want 10", i, {r_busy1, r_busy}); else passed++;
         total++; if ({r_hi, r_lo} !== {e.hi, e.lo}) $display("FAIL mult%0d_result: got %h_%h want %h_%h", i, r_hi, r_lo, e.hi, e.lo); else passed++;
         total++; if (r_after !== 1'b0) $display("FAIL mult%0d_pulse_width: got %b want 0", i, r_after); else passed++;
      end
      total++; if ({hi, lo} !== {e.hi, e.lo}) $display("FAIL mult_hold: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); else passed++;
   endtask

   task automatic test_div;
      logic [W-1:0] ta[8];
      logic [W-1:0] tb[8];
      int           sa, sd;
      exp_t         e;
      ta[0] = 32'hFFFFFFF9;   tb[0] = 32'd2;
      ta[1] = 32'h80000000;   tb[1] = 32'hFFFFFFFF;
      ta[2] = 32'd100;        tb[2] = 32'hFFFFFFF9;
      ta[3] = 32'd3;          tb[3] = 32'd10;
      ta[4] = 32'h80000000;   tb[4] = 32'd7;
      for (int i = 5; i < 8; i++) begin
         ta[i] = $urandom;
         tb[i] = (i == 5) ? 32'($urandom_range(1, 20)) : 32'($urandom);
         if (tb[i] == 0 || tb[i] == 32'hFFFFFFFF) tb[i] = 32'd3;
      end
      for (int i = 0; i < 8; i++) begin
         if (ta[i] == 32'h80000000 && tb[i] == 32'hFFFFFFFF) begin
            e.lo = 32'h80000000;
            e.hi = 32'h0;
         end else begin
            sa = $signed(ta[i]);
            sd = $signed(tb[i]);
            e.lo = 32'(sa / sd);
            e.hi = 32'(sa % sd);
         end
         sb.push_back(e);
         run_op(1'b0, 1'b1, ta[i], tb[i]);
         e = sb.pop_front();
         total++; if (r_n !== LAT) $display("FAIL div%0d_latency: got %0d want %0d", i, r_n, LAT); else passed++;
         total++; if ({r_md, r_dd, r_dz} !== 3'b010) $display("FAIL div%0d_done: got %b want 010", i, {r_md, r_dd, r_dz}); else passed++;
         total++; if ({r_busy1, r_busy} !== 2'b10) $display("FAIL div%0d_busy: got %b want 10", i, {r_busy1, r_busy}); else passed++;
         total++; if ({r_hi, r_lo} !== {e.hi, e.lo}) $display("FAIL div%0d_result: got hi=%h lo=%h want hi=%h lo=%h", i, r_hi, r_lo, e.hi, e.lo); else passed++;
         total++; if (r_after !== 1'b0) $display("FAIL div%0d_pulse_width: got %b want 0", i, r_after); else passed++;
      end
   endtask

   task automatic test_div_zero;
      exp_t e;
`ifdef MULTDIV_DIVZERO_EN
      e.hi = hi;
      e.lo = lo;
      sb.push_back(e);
      run_op(1'b0, 1'b1, 32'd5, 32'd0);
      e = sb.pop_front();
      total++; if (r_n !== 1) $display("FAIL dz_latency: got %0d want 1", r_n); else passed++;
      total++; if ({r_md, r_dd, r_dz} !== 3'b011) $display("FAIL dz_flags: got %b want 011", {r_md, r_dd, r_dz}); else passed++;
      total++; if ({r_hi, r_lo} !== {e.hi, e.lo}) $display("FAIL dz_hold: got %h_%h want %h_%h", r_hi, r_lo, e.hi, e.lo); else passed++;
      total++; if (r_after !== 1'b0) $display("FAIL dz_pulse_width: got %b want 0", r_after); else passed++;
`else
      e.hi = 32'd5;
      e.lo = 32'hFFFFFFFF;
      sb.push_back(e);
      e.hi = 32'hFFFFFFFB;
      e.lo = 32'd1;
      sb.push_back(e);
      for (int i = 0; i < 2; i++) begin
         run_op(1'b0, 1'b1, (i == 0) ? 32'd5 : 32'hFFFFFFFB, 32'd0);
         e = sb.pop_front();
         total++; if (r_n !== LAT) $display("FAIL dz%0d_latency: got %0d want %0d", i, r_n, LAT); else passed++;
         total++; if ({r_md, r_dd} !== 2'b01) $display("FAIL dz%0d_done: got %b want 01", i, {r_md, r_dd}); else passed++;
         total++; if ({r_hi, r_lo} !== {e.hi, e.lo}) $display("FAIL dz%0d_result: got hi=%h lo=%h want hi=%h lo=%h", i, r_hi, r_lo, e.hi, e.lo); else passed++;
      end
`endif
   endtask

   task automatic test_start_conflicts;
      exp_t e;
      int   stray;
      e.hi = 32'd0;
      e.lo = 32'd12;
      sb.push_back(e);
      poke_at = 10;
      run_op(1'b1, 1'b1, 32'd3, 32'd4);
      poke_at = -1;
      e = sb.pop_front();
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (div_done || mult_done) stray++;
      end
      total++; if (r_n !== LAT) $display("FAIL both_latency: got %0d want %0d", r_n, LAT); else passed++;
      total++; if ({r_md, r_dd} !== 2'b10) $display("FAIL both_done: got %b want 10", {r_md, r_dd}); else passed++;
      total++; if ({r_hi, r_lo} !== {e.hi, e.lo}) $display("FAIL both_result: got %h_%h want %h_%h", r_hi, r_lo, e.hi, e.lo); else passed++;
      total++; if (stray !== 0) $display("FAIL busy_start_ignored: got %0d stray done pulses want 0", stray); else passed++;
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int   stray;
      @(negedge clock);
      mult_start = 1; op_a = 32'hFFFF0000; op_b = 32'h00012345;
      @(posedge clock);
      @(negedge clock);
      mult_start = 0;
      repeat (15) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      total++; if ({hi, lo} !== '0) $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); else passed++;
      total++; if ({busy, mult_done, div_done} !== 3'b000) $display("FAIL midreset_ctl: got %b want 000", {busy, mult_done, div_done}); else passed++;
      @(negedge clock);
      reset = 1'b1;
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (mult_done || div_done || busy) stray++;
      end
      total++; if (stray !== 0) $display("FAIL midreset_aborted: got %0d active cycles want 0", stray); else passed++;
      e.hi = 32'hFFFFFFFF;
      e.lo = 32'hFFFFFFD6;
      sb.push_back(e);
      run_op(1'b1, 1'b0, 32'd6, 32'hFFFFFFF9);
      e = sb.pop_front();
      total++; if (r_n !== LAT) $display("FAIL postreset_latency: got %0d want %0d", r_n, LAT); else passed++;
      total++; if ({r_hi, r_lo} !== {e.hi, e.lo}) $display("FAIL postreset_result: got %h_%h want %h_%h", r_hi, r_lo, e.hi, e.lo); else passed++;
   endtask

   initial begin
      poke_at = -1;
      test_reset;
      test_mult;
      test_div;
      test_div_zero;
      test_start_conflicts;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
